lut_map_seq: RTL and testbench
==============================

Name: lut_map_seq

Overview:
- Parametrised, registered successor to the team's fixed 3-bit to 2-bit code-mapping block.
- Maps an IW-bit input code to an OW-bit output code through a 2^IW-entry table. The table resets to the INIT parameter and can be reprogrammed at run time through a write port.
- Input and output use valid/ready handshakes with a one-entry output register.
- A saturating counter tracks how many lookups have been accepted. The block sits between a code producer and a consumer, in the lab datapath.

Parameters:
- IW, 3: input code width. Table depth is 2^IW.
- OW, 2: output code width.
- CW, 8: lookup counter width.
- INIT, 16'h798D: reset table contents, width OW*2^IW. Entry k is INIT[OW*k+OW-1 : OW*k]. The default reproduces the legacy mapping 0->01, 1->11, 2->00, 3->10, 4->01, 5->10, 6->11, 7->01.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input code present
- in_ready  out  1  block can accept a code this cycle
- in_data  in  IW  input code
- out_valid  out  1  out_data holds a result
- out_ready  in  1  consumer accepts the result
- out_data  out  OW  mapped code
- wr_en  in  1  table write strobe
- wr_addr  in  IW  table entry to write
- wr_data  in  OW  new entry value
- cnt_clr  in  1  clear the lookup counter
- lookup_cnt  out  CW  number of accepted lookups, saturating

Behaviour:
- Reset (rst=1 at a clock edge):
  - table <= INIT; out_valid <= 0; out_data <= 0; lookup_cnt <= 0.
  - wr_en and in_valid are ignored that cycle.
  - Reset mid-transfer drops any held result.
- in_ready = !out_valid || out_ready. This is combinational; there is no combinational path from in_valid to in_ready.
- Accept condition: in_valid && in_ready. On accept, out_data <= table[in_data] and out_valid <= 1 at the next edge. Latency is 1 cycle.
- A result that is not taken (out_valid=1, out_ready=0):
  - out_data and out_valid hold stable.
  - in_ready=0.
  - A later table write does not alter the held result.
- Result taken with no new accept (out_valid && out_ready && !accept): out_valid <= 0. out_data keeps its last value, which is don't-care.
- Back-to-back operation: with out_ready held at 1, one lookup is accepted per cycle at full throughput.
- Table write: when wr_en=1, table[wr_addr] <= wr_data at the edge. Writes are allowed at any time, independent of the handshake.
- Write and lookup to the same entry in the same cycle: write-first bypass. The result is wr_data.
- Write and lookup to different entries: the lookup uses the stored value.
- Counter:
  - Increments by 1 on each accept.
  - Saturates at 2^CW-1 and holds there; it never wraps.
  - cnt_clr=1 sets it to 0 at the edge. If cnt_clr and an accept occur in the same cycle, cnt_clr wins: the counter becomes 0 and that accept is not counted.
- All widths are unsigned. The table is implemented as registers, with no RAM inference requirement.

Decomposition:
- Package lut_map_pkg: a function computing depth (1<<IW) and the legacy INIT constant LEGACY_3X2_INIT = 16'h798D.
- One sub-module, sat_counter (params CW; ports clk, rst, clr, inc, cnt), holds the saturate/clear priority logic.
- Table, bypass and output register stay in lut_map_seq.

Test Plan:
- Reset, then sweep in_data 0..7 with in_valid=1 and out_ready=1 -> one cycle later out_data = 01, 11, 00, 10, 01, 10, 11, 01 in order; lookup_cnt = 8.
- Backpressure: accept code 1, hold out_ready=0 for 3 cycles while in_valid=1 with code 2 -> out_data stays 11 and in_ready=0 for all 3 cycles. Release out_ready -> the next result is 00 and lookup_cnt increments only for the accepted transfers.
- Reprogram: write wr_addr=5, wr_data=00, then look up 5 -> result 00. In the same cycle as that write, a lookup of 4 -> result 01.
- Same-cycle write/lookup: wr_en=1, wr_addr=3, wr_data=11 together with an accept of in_data=3 -> out_data=11 on the next cycle.
- Counter (CW=8): 300 accepts -> lookup_cnt=255. cnt_clr asserted in the same cycle as an accept -> lookup_cnt=0. One further accept -> lookup_cnt=1.
- Reset mid-operation: with out_valid=1 held and table entry 0 rewritten to 10, assert rst -> out_valid=0, lookup_cnt=0, and a lookup of 0 returns 01 (INIT restored).

Source files
------------

// File: rtl/lut_map_pkg.sv
// Shared constants and helpers for the parametrised code-mapping table.
// Holds the legacy 3-bit to 2-bit mapping so instances can reproduce it.
package lut_map_pkg;

    // Legacy mapping 0->01, 1->11, 2->00, 3->10, 4->01, 5->10, 6->11, 7->01.
    localparam logic [15:0] LEGACY_3X2_INIT = 16'h798D;

    function automatic int lut_depth(input int iw);
        return 1 << iw;
    endfunction

endpackage

// File: rtl/lut_map_seq_sat_counter.sv
// Saturating up-counter with a synchronous clear.
// A clear takes priority over an increment in the same cycle.
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CW{1'b1}})) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/lut_map_seq.sv
// Registered IW-to-OW code mapper with a run-time writable table,
// valid/ready handshakes on both sides and a saturating lookup counter.
module lut_map_seq
    import lut_map_pkg::*;
#(
    parameter int                    IW   = 3,
    parameter int                    OW   = 2,
    parameter int                    CW   = 8,
    parameter logic [OW*(2**IW)-1:0] INIT = LEGACY_3X2_INIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_addr,
    input  logic [OW-1:0] wr_data,
    input  logic          cnt_clr,
    output logic [CW-1:0] lookup_cnt
);

    localparam int DEPTH = lut_depth(IW);

    logic [OW-1:0] tbl [DEPTH];
    logic          accept;
    logic [OW-1:0] lookup;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Write-first: a lookup of the entry being written sees the new value.
    assign lookup = (wr_en && (wr_addr == in_data)) ? wr_data : tbl[in_data];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                tbl[k] <= INIT[OW*k +: OW];
            end
        end else if (wr_en) begin
            tbl[wr_addr] <= wr_data;
        end
    end

    // The held result is a copy, so later table writes never disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= lookup;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    sat_counter #(
        .CW (CW)
    ) u_sat_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (accept),
        .cnt (lookup_cnt)
    );

endmodule

// File: tb/tb_lut_map_seq.sv
// Self-checking bench for lut_map_seq: directed scenarios followed by
// randomized traffic, all compared against a behavioural table model.
module tb_lut_map_seq;

    localparam int IW      = 3;
    localparam int OW      = 2;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          wr_en;
    logic [IW-1:0] wr_addr;
    logic [OW-1:0] wr_data;
    logic          cnt_clr;
    logic [CW-1:0] lookup_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    int legacy [8] = '{1, 3, 0, 2, 1, 2, 3, 1};
    int m_tbl  [8];
    int m_valid = 0;
    int m_data  = 0;
    int m_cnt   = 0;

    always #5 clk = ~clk;

    lut_map_seq #(
        .IW (IW),
        .OW (OW),
        .CW (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cnt_clr    (cnt_clr),
        .lookup_cnt (lookup_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: model the edge from the current inputs, then compare.
    task automatic cycle();
        bit acc;
        #1;
        if (!rst) check_eq("in_ready", in_ready, 32'(m_valid == 0 || out_ready));
        acc = in_valid && (m_valid == 0 || out_ready);
        if (rst) begin
            for (int k = 0; k < 8; k++) m_tbl[k] = legacy[k];
            m_valid = 0;
            m_data  = 0;
            m_cnt   = 0;
        end else begin
            if (wr_en) m_tbl[wr_addr] = int'(wr_data);
            if (acc) begin
                m_valid = 1;
                m_data  = m_tbl[in_data];
            end else if (out_ready) begin
                m_valid = 0;
            end
            if (cnt_clr)  m_cnt = 0;
            else if (acc) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end
        @(posedge clk);
        #1;
        check_eq("out_valid", out_valid, m_valid);
        if (m_valid != 0) check_eq("out_data", out_data, m_data);
        check_eq("lookup_cnt", lookup_cnt, m_cnt);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; cnt_clr = 1'b0;
        cycle();
        cycle();
        check_eq("rst_out_data", out_data, 0);
        rst = 1'b0;

        // Legacy mapping sweep at full throughput.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = IW'(i);
            cycle();
            check_eq("sweep_data", out_data, legacy[i]);
        end
        check_eq("sweep_cnt", lookup_cnt, 8);
        in_valid = 1'b0;
        cycle();

        // Backpressure: a held result survives a stalled upstream.
        in_valid = 1'b1; in_data = 3'd1; out_ready = 1'b1;
        cycle();
        in_data = 3'd2; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("bp_in_ready", in_ready, 0);
            cycle();
            check_eq("bp_hold", out_data, 3);
        end
        out_ready = 1'b1;
        cycle();
        check_eq("bp_release", out_data, 0);
        check_eq("bp_cnt", lookup_cnt, 10);
        in_valid = 1'b0;
        cycle();

        // Reprogram entry 5 while looking up a different entry.
        in_valid = 1'b1; in_data = 3'd4;
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 2'b00;
        cycle();
        check_eq("wr_other", out_data, 1);
        wr_en = 1'b0; in_data = 3'd5;
        cycle();
        check_eq("wr_readback", out_data, 0);

        // Same-cycle write and lookup of one entry.
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 2'b11; in_data = 3'd3;
        cycle();
        check_eq("bypass", out_data, 3);
        wr_en = 1'b0;

        // Counter saturation and clear priority.
        in_valid = 1'b0; cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_data = IW'($urandom_range(0, 7));
            cycle();
        end
        check_eq("cnt_sat", lookup_cnt, 255);
        cnt_clr = 1'b1;
        cycle();
        check_eq("cnt_clr_win", lookup_cnt, 0);
        cnt_clr = 1'b0;
        cycle();
        check_eq("cnt_after_clr", lookup_cnt, 1);

        // Reset while a result is held and entry 0 has been rewritten.
        in_valid = 1'b0; out_ready = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 2'b10;
        cycle();
        check_eq("pre_rst_valid", out_valid, 1);
        wr_en = 1'b0; rst = 1'b1;
        cycle();
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_cnt", lookup_cnt, 0);
        rst = 1'b0; in_valid = 1'b1; in_data = 3'd0; out_ready = 1'b1;
        cycle();
        check_eq("rst_init", out_data, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = IW'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 2) != 0);
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_addr   = IW'($urandom_range(0, 7));
            wr_data   = OW'($urandom_range(0, 3));
            cnt_clr   = ($urandom_range(0, 31) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
